// File: rtl/vector_pixel_streamer_if.sv
// Read port between the pixel streamer and vector data memory.
// The streamer drives the request and address; memory returns the 8-lane word one cycle later.
interface vector_pixel_streamer_if #(
    parameter int N      = 20,
    parameter int ADDR_W = 16
);
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [8*N-1:0]    rd_data;

    modport master (output rd_en, output rd_addr, input rd_data);
    modport slave  (input rd_en, input rd_addr, output rd_data);
endinterface

// File: rtl/vector_pixel_streamer.sv
// Prefetches 8-lane image words and serialises lane low bytes into one greyscale pixel per VGA strobe.
// Latency: colour 1 cycle after pix_en; read data expected 1 cycle after rd_en.
// Backpressure: fetches stall when FIFO occupancy plus the in-flight word reaches FIFO_DEPTH.
module vector_pixel_streamer #(
    parameter int N          = 20,
    parameter int IMG_W      = 160,
    parameter int IMG_H      = 120,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 16
) (
    input  logic                    CLK,
    input  logic                    reset,
    input  logic                    frame_start,
    input  logic                    pix_en,
    input  logic [9:0]              hcount,
    input  logic [9:0]              vcount,
    vector_pixel_streamer_if.master mem,
    output logic [7:0]              color,
    output logic                    underflow
);
    localparam int WORDS = IMG_W * IMG_H / 8;
    localparam int CNT_W = $clog2(WORDS + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FILL = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;

    localparam logic [CNT_W-1:0] WORDS_C   = CNT_W'(WORDS);
    localparam logic [PTR_W:0]   DEPTH_C   = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W+1:0] DEPTH_OCC = (PTR_W + 2)'(FIFO_DEPTH);
    localparam logic [9:0]       IMG_W_C   = 10'(IMG_W);
    localparam logic [9:0]       IMG_H_C   = 10'(IMG_H);

    logic [1:0]        state;
    logic [63:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic              inflight;
    logic [2:0]        lane_ptr;
    logic [CNT_W-1:0]  fetch_cnt;
    logic [CNT_W-1:0]  consume_cnt;
    logic [ADDR_W-1:0] rd_addr_q;

    logic [63:0]       push_word;
    logic [PTR_W+1:0]  occupancy;
    logic              active;
    logic              in_win;
    logic              fifo_empty;
    logic              issue;
    logic              push;
    logic              pix_req;
    logic              pop;
    logic [7:0]        head_byte;
    logic              unused_lane_bits;

    // Only the low byte of each lane is kept; the rest of the lane is greyscale-irrelevant.
    always_comb begin
        push_word = '0;
        for (int k = 0; k < 8; k++) begin
            push_word[k*8 +: 8] = mem.rd_data[k*N +: 8];
        end
    end

    assign unused_lane_bits = ^mem.rd_data;

    // A word returning in a frame_start cycle belongs to the old frame and is dropped.
    assign push = inflight && !frame_start;

    always_comb begin
        active     = (state == S_FILL) || (state == S_RUN);
        in_win     = (hcount < IMG_W_C) && (vcount < IMG_H_C);
        fifo_empty = (count == '0);
        occupancy  = {1'b0, count} + {{(PTR_W + 1){1'b0}}, inflight};
        issue      = reset && !frame_start && active &&
                     (fetch_cnt < WORDS_C) && (occupancy < DEPTH_OCC);
        pix_req    = pix_en && !frame_start && (state == S_RUN) && in_win;
        pop        = pix_req && !fifo_empty && (lane_ptr == 3'd7);
        head_byte  = fifo_mem[rd_ptr][{lane_ptr, 3'b000} +: 8];
    end

    assign mem.rd_en   = issue;
    assign mem.rd_addr = rd_addr_q;

    always_ff @(posedge CLK) begin
        if (reset && push) begin
            fifo_mem[wr_ptr] <= push_word;
        end
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            state       <= S_IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            inflight    <= 1'b0;
            lane_ptr    <= 3'd0;
            fetch_cnt   <= '0;
            consume_cnt <= '0;
            rd_addr_q   <= '0;
            color       <= 8'd0;
            underflow   <= 1'b0;
        end else if (frame_start) begin
            state       <= S_FILL;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            inflight    <= 1'b0;
            lane_ptr    <= 3'd0;
            fetch_cnt   <= '0;
            consume_cnt <= '0;
            rd_addr_q   <= '0;
            if (pix_en) begin
                color <= 8'd0;
            end
        end else begin
            inflight <= issue;
            if (issue) begin
                rd_addr_q <= rd_addr_q + 1'b1;
                fetch_cnt <= fetch_cnt + 1'b1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase

            if (pix_en) begin
                if (pix_req && !fifo_empty) begin
                    color    <= head_byte;
                    lane_ptr <= lane_ptr + 1'b1;
                    if (pop) begin
                        rd_ptr      <= rd_ptr + 1'b1;
                        consume_cnt <= consume_cnt + 1'b1;
                    end
                end else begin
                    color <= 8'd0;
                    if (pix_req) begin
                        underflow <= 1'b1;
                    end
                end
            end

            unique case (state)
                S_FILL: if ((count == DEPTH_C) || (fetch_cnt == WORDS_C)) state <= S_RUN;
                S_RUN:  if (pop && (consume_cnt == WORDS_C - 1'b1)) state <= S_IDLE;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_vector_pixel_streamer.sv
// Randomised bench for vector_pixel_streamer: pixel-index reference model feeding a colour scoreboard,
// plus an independent read-address monitor.
module tb_vector_pixel_streamer;
    localparam int N      = 20;
    localparam int IMG_W  = 160;
    localparam int IMG_H  = 120;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 16;
    localparam int WORDS  = IMG_W * IMG_H / 8;

    logic       CLK = 1'b0;
    logic       reset = 1'b0;
    logic       frame_start = 1'b0;
    logic       pix_en = 1'b0;
    logic [9:0] hcount = '0;
    logic [9:0] vcount = '0;
    logic [7:0] color;
    logic       underflow;

    vector_pixel_streamer_if #(.N(N), .ADDR_W(ADDR_W)) mif ();

    vector_pixel_streamer #(
        .N(N), .IMG_W(IMG_W), .IMG_H(IMG_H), .FIFO_DEPTH(DEPTH), .ADDR_W(ADDR_W)
    ) u_dut (
        .CLK         (CLK),
        .reset       (reset),
        .frame_start (frame_start),
        .pix_en      (pix_en),
        .hcount      (hcount),
        .vcount      (vcount),
        .mem         (mif),
        .color       (color),
        .underflow   (underflow)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Memory model: lane k of word a holds (8a+k) mod 256 in its low byte, random upper bits.
    logic              req;
    logic [ADDR_W-1:0] req_addr;
    always @(negedge CLK) begin
        req      = mif.rd_en;
        req_addr = mif.rd_addr;
    end
    always @(posedge CLK) begin
        logic [8*N-1:0] w;
        logic [N-1:0]   lane;
        for (int k = 0; k < 8; k++) begin
            lane = N'($urandom);
            if (req) lane[7:0] = 8'(8 * int'(req_addr) + k);
            w[k*N +: N] = lane;
        end
        mif.rd_data <= w;
    end

    // Reference model: pixels of the image are simply 0,1,2,... in raster order.
    int   m_p = 0;
    bit   m_run = 0;
    int   m_budget = 0;
    bit   m_under = 0;
    logic [7:0] exp_q [$];

    // Read-address monitor: requests within a frame must walk 0,1,2,... once each.
    int exp_addr = 0;
    int last_addr = -1;
    always @(negedge CLK) begin
        if (!reset || frame_start) begin
            exp_addr = 0;
        end else if (mif.rd_en) begin
            chk("rd_addr_seq", 32'(mif.rd_addr), 32'(exp_addr));
            last_addr = exp_addr;
            exp_addr++;
        end
    end

    // Colour monitor: a strobe seen this cycle is scored against the queue one cycle later.
    bit pend = 0;
    always @(negedge CLK) begin
        if (pend) begin
            if (exp_q.size() == 0) begin
                failures++;
                checks++;
                $display("FAIL color_unexpected: got %0d with no expected entry", color);
            end else begin
                chk("color", 32'(color), 32'(exp_q.pop_front()));
            end
        end
        pend = pix_en && reset;
    end

    task automatic cyc(int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic pixel(int h, int v, int gap);
        logic [7:0] e;
        hcount = 10'(h);
        vcount = 10'(v);
        pix_en = 1'b1;
        e = 8'd0;
        if (m_run && h < IMG_W && v < IMG_H) begin
            if (m_budget == 0) begin
                m_under = 1'b1;
            end else begin
                e = 8'(m_p % 256);
                m_p++;
                m_budget--;
                if (m_p == IMG_W * IMG_H) m_run = 1'b0;
            end
        end
        exp_q.push_back(e);
        cyc(1);
        pix_en = 1'b0;
        cyc(gap);
    endtask

    task automatic start_frame();
        frame_start = 1'b1;
        m_p = 0;
        m_run = 1'b1;
        m_budget = 1 << 30;
        cyc(1);
        frame_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            chk("prefetch_rd_en", 32'(mif.rd_en), 32'(i < 4));
            if (i < 4) chk("prefetch_addr", 32'(mif.rd_addr), 32'(i));
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        bit saw;

        // Reset with random inputs
        for (int i = 0; i < 3; i++) begin
            frame_start = 1'($urandom);
            pix_en      = 1'($urandom);
            hcount      = 10'($urandom);
            vcount      = 10'($urandom);
            cyc(1);
        end
        frame_start = 1'b0;
        pix_en = 1'b0;
        chk("reset_rd_en", 32'(mif.rd_en), 0);
        chk("reset_rd_addr", 32'(mif.rd_addr), 0);
        chk("reset_color", 32'(color), 0);
        chk("reset_underflow", 32'(underflow), 0);
        reset = 1'b1;
        cyc(3);
        chk("idle_rd_en", 32'(mif.rd_en), 0);

        // Full-frame stream with random strobe spacing and blanking strobes
        start_frame();
        for (int v = 0; v < IMG_H; v++) begin
            for (int h = 0; h < IMG_W; h++) pixel(h, v, int'($urandom_range(0, 2)));
            repeat ($urandom_range(1, 3)) pixel(int'($urandom_range(IMG_W, 799)), v, 0);
        end
        cyc(3);
        chk("last_addr", 32'(last_addr), 32'(WORDS - 1));
        chk("total_reads", 32'(exp_addr), 32'(WORDS));
        chk("stream_underflow", 32'(underflow), 0);
        // After the last pixel the block is idle: in-window strobes yield 0 without underflow
        pixel(5, 5, 1);
        pixel(100, 60, 1);
        chk("idle_underflow", 32'(underflow), 0);
        chk("idle_no_fetch", 32'(mif.rd_en), 0);

        // Mid-line restart coinciding with a read return
        start_frame();
        saw = 1'b0;
        for (int i = 0; i < 40; i++) begin
            hcount = 10'(i);
            vcount = 10'd0;
            pix_en = 1'b1;
            exp_q.push_back(8'(m_p % 256));
            m_p++;
            @(negedge CLK);
            saw = mif.rd_en;
            @(posedge CLK);
            #1;
            pix_en = 1'b0;
            if (i >= 10 && saw) break;
        end
        chk("restart_trigger", 32'(saw), 1);
        start_frame();
        for (int h = 0; h < 24; h++) pixel(h, 0, int'($urandom_range(0, 1)));
        chk("restart_underflow", 32'(underflow), 0);

        // Underflow: returns are lost once the FIFO is full, so 32 pixels drain it
        start_frame();
        cyc(2);
        force u_dut.push = 1'b0;
        m_budget = 32;
        for (int h = 0; h < 40; h++) begin
            pixel(h, 0, 1);
            if (h == 31 || h == 33) chk("underflow_flag", 32'(underflow), 32'(m_under));
        end
        release u_dut.push;
        start_frame();
        chk("underflow_sticky", 32'(underflow), 1);
        for (int h = 0; h < 16; h++) pixel(h, 0, 1);
        chk("underflow_sticky_end", 32'(underflow), 1);

        cyc(3);
        chk("scoreboard_drain", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
